// File: rtl/minterm_sweep_checker_if.sv
// Bundle between the minterm sweep checker and the logic under test.
//   start      : request a new sweep (sampled only while idle)
//   stim       : minterm currently applied; stim[N_IN-1] is the MSB input
//   resp_a/b   : responses of the two implementations being compared
//   busy/done  : sweep in progress / one-cycle completion pulse
//   pass, err_count, first_fail, truth_tbl : results of the last sweep
// The master modport is the checker; the slave modport is the environment.
interface minterm_sweep_checker_if #(
    parameter int N_IN = 2
);
    logic                 start;
    logic [N_IN-1:0]      stim;
    logic                 resp_a;
    logic                 resp_b;
    logic                 busy;
    logic                 done;
    logic                 pass;
    logic [N_IN:0]        err_count;
    logic [N_IN-1:0]      first_fail;
    logic [2**N_IN-1:0]   truth_tbl;

    modport master (
        input  start, resp_a, resp_b,
        output stim, busy, done, pass, err_count, first_fail, truth_tbl
    );

    modport slave (
        output start, resp_a, resp_b,
        input  stim, busy, done, pass, err_count, first_fail, truth_tbl
    );
endinterface

// File: rtl/minterm_sweep_checker.sv
// Exhaustive equivalence checker for an N_IN-input combinational function.
// Walks stim through every minterm, holding each for SETTLE+1 cycles, and
// samples resp_a/resp_b on the last cycle of each hold. Counts mismatches,
// remembers the lowest mismatching minterm and rebuilds resp_a's truth table.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-high; clears all state and outputs
//   bus   : minterm_sweep_checker_if.master (start, stim, resp_a/b, results)
module minterm_sweep_checker #(
    parameter int N_IN   = 2,
    parameter int SETTLE = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    minterm_sweep_checker_if.master bus
);
    // Hold counter must hold SETTLE; keep at least one bit when SETTLE == 0.
    localparam int HW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

    typedef enum logic [1:0] {IDLE, HOLD, DONE} state_t;

    state_t        state, state_nxt;
    logic [HW-1:0] hold_cnt;
    logic          last;
    logic          sample;
    logic          mismatch;

    assign last     = (bus.stim == {N_IN{1'b1}});
    assign sample   = (state == HOLD) && (hold_cnt == '0);
    assign mismatch = (bus.resp_a != bus.resp_b);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = HOLD;
            HOLD:    if (sample && last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_cnt       <= '0;
            bus.stim       <= '0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.pass       <= 1'b0;
            bus.err_count  <= '0;
            bus.first_fail <= '0;
            bus.truth_tbl  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        hold_cnt       <= HW'(SETTLE);
                        bus.stim       <= '0;
                        bus.busy       <= 1'b1;
                        bus.pass       <= 1'b0;
                        bus.err_count  <= '0;
                        bus.first_fail <= '0;
                        bus.truth_tbl  <= '0;
                    end
                end
                HOLD: begin
                    if (hold_cnt != '0) begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end else begin
                        bus.truth_tbl[bus.stim] <= bus.resp_a;
                        if (mismatch) begin
                            bus.err_count <= bus.err_count + 1'b1;
                            // err_count still zero means this is the first miss.
                            if (bus.err_count == '0) bus.first_fail <= bus.stim;
                        end
                        if (last) begin
                            bus.busy <= 1'b0;
                            bus.done <= 1'b1;
                            // Fold in the final sample so pass is valid with done.
                            bus.pass <= (bus.err_count == '0) && !mismatch;
                        end else begin
                            bus.stim <= bus.stim + 1'b1;
                            hold_cnt <= HW'(SETTLE);
                        end
                    end
                end
                DONE: begin
                    bus.done <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_minterm_sweep_checker.sv
// Scoreboard bench: sweep launches push expected results; a negedge monitor
// pops and compares on every done pulse. Two instances cover SETTLE=0 and 2.
module tb_minterm_sweep_checker;
    typedef struct {
        int err;
        int ff;
        int tt;
        int pass;
        int busy;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic start0, start1;
    int   mode;
    int   tests = 0;
    int   fails = 0;
    exp_t q0[$];
    exp_t q1[$];
    int   bcnt[2];
    int   serr[2];
    int   dones[2];
    bit   pb[2];
    int   settle_of[2] = '{0, 2};

    always #5 clk = ~clk;

    minterm_sweep_checker_if #(.N_IN(2)) b0 ();
    minterm_sweep_checker_if #(.N_IN(2)) b1 ();

    minterm_sweep_checker #(.N_IN(2), .SETTLE(0)) dut0 (.clk(clk), .reset(reset), .bus(b0));
    minterm_sweep_checker #(.N_IN(2), .SETTLE(2)) dut1 (.clk(clk), .reset(reset), .bus(b1));

    // f5 = a'.b with a = stim[1], b = stim[0]
    function automatic logic f5(input logic [1:0] s);
        return ~s[1] & s[0];
    endfunction

    function automatic logic fb(input logic [1:0] s, input int m);
        case (m)
            0:       return f5(s);
            1:       return s[1] & ~s[0];
            default: return ~f5(s);
        endcase
    endfunction

    assign b0.start  = start0;
    assign b1.start  = start1;
    assign b0.resp_a = f5(b0.stim);
    assign b1.resp_a = f5(b1.stim);
    assign b0.resp_b = fb(b0.stim, mode);
    assign b1.resp_b = fb(b1.stim, mode);

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic mon(input int i, input logic b, input logic d, input logic [1:0] s,
                       input logic [2:0] ec, input logic [1:0] ff, input logic [3:0] tt,
                       input logic p);
        exp_t e;
        int   n;
        if (b) begin
            if (int'(s) != (bcnt[i] / (settle_of[i] + 1)) % 4) serr[i]++;
            bcnt[i]++;
        end
        if (d) begin
            dones[i]++;
            n = (i == 0) ? q0.size() : q1.size();
            if (n == 0) begin
                tests++;
                fails++;
                $display("FAIL spurious_done dut%0d: got done with no sweep pending", i);
            end else begin
                e = (i == 0) ? q0.pop_front() : q1.pop_front();
                chk($sformatf("busy_cycles%0d", i), bcnt[i], e.busy);
                chk($sformatf("stim_seq%0d", i), serr[i], 0);
                chk($sformatf("done_after_busy%0d", i), int'(pb[i] && !b), 1);
                chk($sformatf("err_count%0d", i), int'(ec), e.err);
                chk($sformatf("first_fail%0d", i), int'(ff), e.ff);
                chk($sformatf("truth_tbl%0d", i), int'(tt), e.tt);
                chk($sformatf("pass%0d", i), int'(p), e.pass);
            end
            bcnt[i] = 0;
            serr[i] = 0;
        end
        pb[i] = b;
    endtask

    always @(negedge clk) begin
        mon(0, b0.busy, b0.done, b0.stim, b0.err_count, b0.first_fail, b0.truth_tbl, b0.pass);
        mon(1, b1.busy, b1.done, b1.stim, b1.err_count, b1.first_fail, b1.truth_tbl, b1.pass);
    end

    // Hand-derived results for the three resp_b wirings.
    task automatic push(input int i, input int m);
        exp_t e;
        e.err  = (m == 0) ? 0 : (m == 1) ? 2 : 4;
        e.ff   = (m == 1) ? 1 : 0;
        e.tt   = 4'b0010;
        e.pass = (m == 0) ? 1 : 0;
        e.busy = 4 * (settle_of[i] + 1);
        if (i == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic wait_done(input int i, input int d0);
        for (int k = 0; k < 60 && dones[i] == d0; k++) @(negedge clk);
        if (dones[i] == d0) begin
            tests++;
            fails++;
            $display("FAIL timeout dut%0d: got no done, expected done within 60 cycles", i);
        end
    endtask

    task automatic run(input int i, input int m);
        int d0;
        d0   = dones[i];
        mode = m;
        push(i, m);
        if (i == 0) start0 = 1'b1; else start1 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
        wait_done(i, d0);
        @(negedge clk);
    endtask

    initial begin
        int d0;
        int k;
        reset  = 1'b1;
        start0 = 1'b0;
        start1 = 1'b0;
        mode   = 0;
        repeat (2) @(negedge clk);
        chk("rst_busy", int'(b0.busy), 0);
        chk("rst_done", int'(b0.done), 0);
        chk("rst_stim", int'(b0.stim), 0);
        chk("rst_err", int'(b0.err_count), 0);
        chk("rst_tt", int'(b0.truth_tbl), 0);
        chk("rst_pass", int'(b1.pass), 0);
        reset = 1'b0;
        @(negedge clk);

        run(0, 0);  // equivalent implementations
        run(0, 1);  // wrong resp_b: two mismatches
        run(0, 2);  // inverted resp_b: all four mismatch, no wrap
        run(1, 0);  // SETTLE=2: 12 busy cycles, done next

        // start held high across a whole sweep: exactly one sweep
        mode = 0;
        d0   = dones[0];
        push(0, 0);
        start0 = 1'b1;
        for (k = 0; k < 60; k++) begin
            @(negedge clk);
            if (b0.done) break;
        end
        start0 = 1'b0;
        repeat (8) @(negedge clk);
        chk("held_start_sweeps", dones[0] - d0, 1);
        chk("held_start_idle", int'(b0.busy), 0);
        chk("idle_stim_hold", int'(b0.stim), 3);
        run(0, 0);  // repeat sweep gives identical results

        // reset mid-sweep at stim=2
        mode = 2;
        push(0, 2);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        for (k = 0; k < 20 && !(b0.busy && b0.stim == 2'd2); k++) @(negedge clk);
        chk("mid_stim", int'(b0.stim), 2);
        chk("mid_err", int'(b0.err_count), 2);
        reset = 1'b1;
        #1;
        chk("arst_busy", int'(b0.busy), 0);
        chk("arst_stim", int'(b0.stim), 0);
        chk("arst_err", int'(b0.err_count), 0);
        chk("arst_tt", int'(b0.truth_tbl), 0);
        q0.delete();
        bcnt[0] = 0;
        serr[0] = 0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run(0, 0);  // restarts from minterm 0

        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
